// File: rtl/async_wb_bridge.sv
// Terminates a 4-phase req/ack handshake into a small FIFO and presents it as a valid/ready stream.
// Latency: req_i edge to ack_o edge is SYNC_STAGES+1 cycles; when the FIFO is full, ack is withheld until a slot frees.
module async_wb_bridge #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic                       ack_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [DATA_W-1:0]          data_o,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int AW = PW + 1;

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   state_t                 state_q, state_d;
   logic                   push, pop, full;
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [DATA_W-1:0]      mem [DEPTH];

   // Raw req_i is used only here; everything downstream sees req_s.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
   end
   assign req_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_s && !full) state_d = ACK;
         ACK:  if (!req_s)         state_d = IDLE;
      endcase
   end

   always_comb begin
      push  = 1'b0;
      ack_o = 1'b0;
      case (state_q)
         IDLE: push  = req_s && !full;
         ACK:  ack_o = 1'b1;
      endcase
   end

   // Wrap bit distinguishes full from empty; full uses registered pointers only.
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count_o = wr_ptr - rd_ptr;
   assign valid_o = (wr_ptr != rd_ptr);
   assign pop     = valid_o && ready_i;
   assign data_o  = valid_o ? mem[rd_ptr[PW-1:0]] : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush_i) mem[wr_ptr[PW-1:0]] <= data_i;
   end

endmodule

// File: tb/tb_async_wb_bridge.sv
// Directed bench for async_wb_bridge: reset, latency, backpressure, back-to-back and flush.
module tb_async_wb_bridge;

   localparam int DATA_W      = 32;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int CW          = 3;

   logic              clk_i   = 1'b0;
   logic              rst_ni  = 1'b0;
   logic              req_i   = 1'b0;
   logic              ready_i = 1'b0;
   logic              flush_i = 1'b0;
   logic [DATA_W-1:0] data_i  = '0;
   logic              ack_o;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;
   logic [CW-1:0]     count_o;

   int n_cmp  = 0;
   int n_fail = 0;

   logic              mon_en  = 1'b0;
   int                max_cnt = 0;
   logic [DATA_W-1:0] rx_q[$];
   logic [DATA_W-1:0] exp_q[$];

   async_wb_bridge #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i),
      .ack_o(ack_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .flush_i(flush_i), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (mon_en && rst_ni) begin
         if (valid_o && ready_i) rx_q.push_back(data_o);
         if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni) !(dut.push && ack_o));
   assert property (@(posedge clk_i) disable iff (!rst_ni) $rose(ack_o) |-> ($past(count_o) != 3'd4));
   assert property (@(posedge clk_i) disable iff (!rst_ni) count_o <= 3'd4);
   assert property (@(posedge clk_i) disable iff (!rst_ni) !valid_o |-> (data_o == '0));

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic wait_ack(input logic lvl, input string tag);
      int i = 0;
      while (ack_o !== lvl && i < 20) begin
         tick();
         i++;
      end
      n_cmp++;
      if (ack_o !== lvl) begin
         n_fail++;
         $display("FAIL %s: ack_o=%b required %b (timeout)", tag, ack_o, lvl);
      end
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input string tag);
      data_i = d;
      req_i  = 1'b1;
      wait_ack(1'b1, tag);
      req_i  = 1'b0;
      wait_ack(1'b0, tag);
   endtask

   task automatic test_reset();
      rst_ni  = 1'b0;
      req_i   = 1'b1;
      data_i  = 32'h1234_5678;
      ready_i = 1'b0;
      repeat (3) tick();
      n_cmp++; if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count_o); end
      n_cmp++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_o); end
      rst_ni = 1'b1;
      repeat (2) tick();
      n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rel_ack_early: got %b want 0", ack_o); end
      tick();
      n_cmp++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL rel_ack_lat: got %b want 1", ack_o); end
      n_cmp++; if (data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL rel_head: got %h want 12345678", data_o); end
      n_cmp++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL rel_count: got %0d want 1", count_o); end
      req_i = 1'b0;
      wait_ack(1'b0, "rel_ack_fall");
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL rel_drain: got %0d want 0", count_o); end

      // Reset mid-handshake, off the clock edge, with req_i still high.
      data_i = 32'hCAFE_0001;
      req_i  = 1'b1;
      repeat (3) tick();
      n_cmp++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL mid_ack_pre: got %b want 1", ack_o); end
      #2 rst_ni = 1'b0;
      #1;
      n_cmp++; if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL mid_ack_async: got %b want 0", ack_o); end
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL mid_count_async: got %0d want 0", count_o); end
      tick();
      rst_ni = 1'b1;
      repeat (3) tick();
      n_cmp++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL recap_ack: got %b want 1", ack_o); end
      n_cmp++; if (data_o !== 32'hCAFE_0001) begin n_fail++; $display("FAIL recap_data: got %h want cafe0001", data_o); end
      req_i = 1'b0;
      wait_ack(1'b0, "recap_ack_fall");
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
   endtask

   task automatic test_single();
      ready_i = 1'b1;
      data_i  = 32'hDEAD_BEEF;
      req_i   = 1'b1;
      repeat (2) tick();
      n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL single_ack_early: got %b want 0", ack_o); end
      tick();
      n_cmp++; if (ack_o !== 1'b1)   begin n_fail++; $display("FAIL single_ack: got %b want 1", ack_o); end
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", valid_o); end
      n_cmp++; if (data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", data_o); end
      tick();
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL single_popped: got %0d want 0", count_o); end
      n_cmp++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL single_data_zero: got %h want 0", data_o); end
      n_cmp++; if (ack_o !== 1'b1)   begin n_fail++; $display("FAIL single_ack_hold: got %b want 1", ack_o); end
      req_i = 1'b0;
      repeat (2) tick();
      n_cmp++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL single_fall_early: got %b want 1", ack_o); end
      tick();
      n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL single_fall_lat: got %b want 0", ack_o); end
      ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      ready_i = 1'b0;
      for (int k = 1; k <= 4; k++) send(DATA_W'(k), "bp_fill");
      n_cmp++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL bp_full: got %0d want 4", count_o); end
      data_i = 32'd5;
      req_i  = 1'b1;
      repeat (6) tick();
      n_cmp++; if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL bp_withheld: got %b want 0", ack_o); end
      n_cmp++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL bp_count_held: got %0d want 4", count_o); end
      n_cmp++; if (data_o !== 32'd1) begin n_fail++; $display("FAIL bp_head1: got %h want 1", data_o); end
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      n_cmp++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL bp_after_pop: got %0d want 3", count_o); end
      n_cmp++; if (data_o !== 32'd2) begin n_fail++; $display("FAIL bp_head2: got %h want 2", data_o); end
      wait_ack(1'b1, "bp_ack5");
      n_cmp++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL bp_count5: got %0d want 4", count_o); end
      req_i = 1'b0;
      wait_ack(1'b0, "bp_ack5_fall");
      ready_i = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         n_cmp++;
         if (valid_o !== 1'b1 || data_o !== DATA_W'(k)) begin
            n_fail++;
            $display("FAIL bp_order: valid=%b data=%h want valid=1 data=%h", valid_o, data_o, DATA_W'(k));
         end
         tick();
      end
      ready_i = 1'b0;
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL bp_empty: got %0d want 0", count_o); end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] d;
      ready_i = 1'b1;
      rx_q.delete();
      exp_q.delete();
      max_cnt = 0;
      mon_en  = 1'b1;
      for (int n = 0; n < 100; n++) begin
         d = $urandom;
         exp_q.push_back(d);
         send(d, "b2b_hs");
      end
      repeat (3) tick();
      mon_en = 1'b0;
      n_cmp++; if (rx_q.size() != 100) begin n_fail++; $display("FAIL b2b_count: got %0d want 100", rx_q.size()); end
      n_cmp++; if (max_cnt > 1) begin n_fail++; $display("FAIL b2b_max_count: got %0d want <=1", max_cnt); end
      for (int n = 0; n < 100 && n < rx_q.size(); n++) begin
         n_cmp++;
         if (rx_q[n] !== exp_q[n]) begin
            n_fail++;
            $display("FAIL b2b_data[%0d]: got %h want %h", n, rx_q[n], exp_q[n]);
         end
      end
      ready_i = 1'b0;
   endtask

   task automatic test_flush();
      ready_i = 1'b0;
      send(32'h11, "fl_fill");
      send(32'h22, "fl_fill");
      send(32'h33, "fl_fill");
      n_cmp++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL fl_pre: got %0d want 3", count_o); end
      data_i = 32'h77;
      req_i  = 1'b1;
      repeat (2) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL fl_count: got %0d want 0", count_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", valid_o); end
      n_cmp++; if (ack_o !== 1'b1)   begin n_fail++; $display("FAIL fl_ack: got %b want 1", ack_o); end
      req_i = 1'b0;
      wait_ack(1'b0, "fl_ack_fall");
      send(32'hA5, "fl_next");
      n_cmp++; if (count_o !== 3'd1)  begin n_fail++; $display("FAIL fl_next_count: got %0d want 1", count_o); end
      n_cmp++; if (data_o !== 32'hA5) begin n_fail++; $display("FAIL fl_next_data: got %h want a5", data_o); end
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      n_cmp++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL fl_drain: got %0d want 0", count_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_drain_valid: got %b want 0", valid_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
